// File: rtl/image_sensor_emulator.sv
// Synthetic parallel-bus camera source: frame/line valid, exposure strobe and
// 12-bit test-pattern pixels with run-time geometry, blanking and pattern.
module image_sensor_emulator #(
  parameter int CNT_W = 12
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             trigger,
  input  logic [CNT_W-1:0] width,
  input  logic [CNT_W-1:0] height,
  input  logic [CNT_W-1:0] hblank,
  input  logic [CNT_W-1:0] vblank,
  input  logic [1:0]       pattern,
  output logic             img_fv,
  output logic             img_lv,
  output logic             img_strobe,
  output logic [11:0]      img_pix,
  output logic             frame_done,
  output logic             busy
);

  typedef enum logic [2:0] {IDLE, SOF, LINE, HBLANK, EOF, VBLANK} state_t;

  state_t           state;
  logic [CNT_W-1:0] x, y, blank_cnt;
  logic [CNT_W-1:0] width_lat, height_lat, hblank_lat, vblank_lat;
  logic [1:0]       pattern_lat;
  logic [11:0]      frame_cnt;
  logic [CNT_W-1:0] x_next, y_next;
  logic             last_x, last_y, last_h, last_v, sof_entry;

  function automatic logic [CNT_W-1:0] clamp(input logic [CNT_W-1:0] v);
    return (v == '0) ? {{(CNT_W-1){1'b0}}, 1'b1} : v;
  endfunction

  function automatic logic [11:0] pixel_value(input logic [1:0] pat, input logic [11:0] px,
                                              input logic [11:0] py, input logic [11:0] fc);
    case (pat)
      2'd0:    return px;
      2'd1:    return py;
      2'd2:    return (px[3] ^ py[3]) ? 12'hFFF : 12'h000;
      default: return px + py + fc;
    endcase
  endfunction

  always_comb begin
    x_next    = x + 1'b1;
    y_next    = y + 1'b1;
    last_x    = (x == width_lat - 1'b1);
    last_y    = (y == height_lat - 1'b1);
    last_h    = (blank_cnt == hblank_lat - 1'b1);
    last_v    = (blank_cnt == vblank_lat - 1'b1);
    sof_entry = ((state == IDLE) && (enable || trigger)) ||
                ((state == VBLANK) && last_v && enable);
  end

  // Frame configuration is sampled once per frame so mid-frame edits wait for the next SOF.
  always_ff @(posedge clk) begin
    if (sof_entry) begin
      width_lat   <= clamp(width);
      height_lat  <= clamp(height);
      hblank_lat  <= clamp(hblank);
      vblank_lat  <= clamp(vblank);
      pattern_lat <= pattern;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      x          <= '0;
      y          <= '0;
      blank_cnt  <= '0;
      frame_cnt  <= '0;
      img_fv     <= 1'b0;
      img_lv     <= 1'b0;
      img_strobe <= 1'b0;
      img_pix    <= '0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (sof_entry) begin
            state  <= SOF;
            img_fv <= 1'b1;
            busy   <= 1'b1;
          end
        end
        SOF: begin
          state   <= LINE;
          x       <= '0;
          y       <= '0;
          img_lv  <= 1'b1;
          img_pix <= pixel_value(pattern_lat, 12'd0, 12'd0, frame_cnt);
        end
        LINE: begin
          if (last_x) begin
            img_lv    <= 1'b0;
            img_pix   <= '0;
            blank_cnt <= '0;
            if (last_y) begin
              state      <= EOF;
              frame_done <= 1'b1;
            end else begin
              state <= HBLANK;
            end
          end else begin
            x       <= x_next;
            img_pix <= pixel_value(pattern_lat, x_next[11:0], y[11:0], frame_cnt);
          end
        end
        HBLANK: begin
          if (last_h) begin
            state   <= LINE;
            x       <= '0;
            y       <= y_next;
            img_lv  <= 1'b1;
            img_pix <= pixel_value(pattern_lat, 12'd0, y_next[11:0], frame_cnt);
          end else begin
            blank_cnt <= blank_cnt + 1'b1;
          end
        end
        EOF: begin
          state      <= VBLANK;
          frame_cnt  <= frame_cnt + 12'd1;
          img_fv     <= 1'b0;
          img_strobe <= 1'b1;
          blank_cnt  <= '0;
        end
        VBLANK: begin
          if (last_v) begin
            img_strobe <= 1'b0;
            blank_cnt  <= '0;
            if (enable) begin
              state  <= SOF;
              img_fv <= 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            blank_cnt <= blank_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_image_sensor_emulator.sv
// Directed bench for image_sensor_emulator: per-cycle bus capture with
// hand-computed expected counts, burst lengths and pixel sequences.
module tb_image_sensor_emulator;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        trigger = 1'b0;
  logic [11:0] width = '0, height = '0, hblank = '0, vblank = '0;
  logic [1:0]  pattern = '0;
  logic        img_fv, img_lv, img_strobe, frame_done, busy;
  logic [11:0] img_pix;

  int checks = 0;
  int failures = 0;

  int fv_cnt, lv_cnt, strobe_cnt, done_cnt, overlap, done_bad, leak, first_fv, idx, cur_run;
  logic prev_lv;
  int pix_q[$];
  int burst_q[$];
  int exp_q[$];

  image_sensor_emulator #(.CNT_W(12)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .trigger(trigger),
    .width(width), .height(height), .hblank(hblank), .vblank(vblank),
    .pattern(pattern), .img_fv(img_fv), .img_lv(img_lv), .img_strobe(img_strobe),
    .img_pix(img_pix), .frame_done(frame_done), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    fv_cnt = 0; lv_cnt = 0; strobe_cnt = 0; done_cnt = 0; overlap = 0;
    done_bad = 0; leak = 0; first_fv = -1; idx = 0; cur_run = 0; prev_lv = 1'b0;
    pix_q.delete();
    burst_q.delete();
  endtask

  // Sample on the falling edge, then release trigger so it spans one rising edge.
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (img_fv) fv_cnt++;
      if (img_fv && first_fv < 0) first_fv = idx;
      if (img_strobe) strobe_cnt++;
      if (img_strobe && img_fv) overlap++;
      if (frame_done) done_cnt++;
      if (frame_done && (!img_fv || img_lv)) done_bad++;
      if (!img_lv && img_pix != 12'd0) leak++;
      if (img_lv) begin
        lv_cnt++;
        cur_run++;
        pix_q.push_back(int'(img_pix));
      end else if (prev_lv) begin
        burst_q.push_back(cur_run);
        cur_run = 0;
      end
      prev_lv = img_lv;
      idx++;
      trigger = 1'b0;
    end
  endtask

  task automatic check_pix(input string tag);
    check({tag, "_pix_len"}, pix_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("%s_pix%0d", tag, i), (i < pix_q.size()) ? pix_q[i] : -1, exp_q[i]);
  endtask

  task automatic check_bursts(input string tag);
    check({tag, "_bursts"}, burst_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("%s_burst%0d", tag, i), (i < burst_q.size()) ? burst_q[i] : -1, exp_q[i]);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_fv"}, int'(img_fv), 0);
    check({tag, "_lv"}, int'(img_lv), 0);
    check({tag, "_strobe"}, int'(img_strobe), 0);
    check({tag, "_pix"}, int'(img_pix), 0);
    check({tag, "_done"}, int'(frame_done), 0);
    check({tag, "_busy"}, int'(busy), 0);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check_idle_outputs("rst");
    reset_n = 1'b1;

    // Single triggered frame: 4x2, hblank 2, vblank 3, horizontal ramp
    width = 12'd4; height = 12'd2; hblank = 12'd2; vblank = 12'd3; pattern = 2'd0;
    clear_mon();
    trigger = 1'b1;
    run(20);
    check("t1_first_fv", first_fv, 0);
    check("t1_fv", fv_cnt, 12);
    check("t1_lv", lv_cnt, 8);
    check("t1_done", done_cnt, 1);
    check("t1_done_pos", done_bad, 0);
    check("t1_strobe", strobe_cnt, 3);
    check("t1_overlap", overlap, 0);
    check("t1_leak", leak, 0);
    check("t1_busy_end", int'(busy), 0);
    exp_q = '{0, 1, 2, 3, 0, 1, 2, 3};
    check_pix("t1");
    exp_q = '{4, 4};
    check_bursts("t1");

    // Free-run moving diagonal, 3x1, three back-to-back frames from frame_cnt 0
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    width = 12'd3; height = 12'd1; hblank = 12'd1; vblank = 12'd1; pattern = 2'd3;
    enable = 1'b1;
    clear_mon();
    run(18);
    check("t2_last_is_vblank", int'(img_strobe), 1);
    enable = 1'b0;
    run(3);
    check("t2_fv", fv_cnt, 15);
    check("t2_strobe", strobe_cnt, 3);
    check("t2_done", done_cnt, 3);
    check("t2_busy_end", int'(busy), 0);
    exp_q = '{0, 1, 2, 1, 2, 3, 2, 3, 4};
    check_pix("t2");

    // All geometry zero clamps to 1
    width = '0; height = '0; hblank = '0; vblank = '0; pattern = 2'd0;
    clear_mon();
    trigger = 1'b1;
    run(8);
    check("t3_fv", fv_cnt, 3);
    check("t3_strobe", strobe_cnt, 1);
    check("t3_done", done_cnt, 1);
    exp_q = '{0};
    check_pix("t3");

    // Width change 4 -> 8 mid-frame, checker pattern, free-run two frames
    width = 12'd4; height = 12'd1; hblank = 12'd1; vblank = 12'd1; pattern = 2'd2;
    enable = 1'b1;
    clear_mon();
    run(2);
    width = 12'd8;
    run(16);
    enable = 1'b0;
    run(2);
    check("t4_fv", fv_cnt, 16);
    check("t4_leak", leak, 0);
    exp_q = '{4, 8};
    check_bursts("t4");
    exp_q = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    check_pix("t4");

    // Checker horizontal toggle at x=8 on a 16-pixel line
    width = 12'd16;
    clear_mon();
    trigger = 1'b1;
    run(22);
    exp_q.delete();
    for (int i = 0; i < 16; i++) exp_q.push_back((i >= 8) ? 4095 : 0);
    check_pix("t4b");

    // Checker vertical toggle at y=8 on a 1x9 frame
    width = 12'd1; height = 12'd9;
    clear_mon();
    trigger = 1'b1;
    run(23);
    check("t4c_fv", fv_cnt, 19);
    exp_q.delete();
    for (int i = 0; i < 9; i++) exp_q.push_back((i >= 8) ? 4095 : 0);
    check_pix("t4c");

    // Vertical ramp 2x3
    width = 12'd2; height = 12'd3; pattern = 2'd1;
    clear_mon();
    trigger = 1'b1;
    run(13);
    check("t4d_fv", fv_cnt, 10);
    exp_q = '{0, 0, 1, 1, 2, 2};
    check_pix("t4d");

    // Enable dropped during LINE, stray trigger mid-frame
    width = 12'd4; height = 12'd2; hblank = 12'd2; vblank = 12'd3; pattern = 2'd0;
    enable = 1'b1;
    clear_mon();
    run(3);
    check("t5_in_line", int'(img_lv), 1);
    enable = 1'b0;
    trigger = 1'b1;
    run(25);
    check("t5_fv", fv_cnt, 12);
    check("t5_strobe", strobe_cnt, 3);
    check("t5_done", done_cnt, 1);
    check("t5_busy_end", int'(busy), 0);

    // Reset during HBLANK, then fresh frame with frame_cnt back at 0
    vblank = 12'd1; pattern = 2'd3;
    clear_mon();
    trigger = 1'b1;
    run(6);
    check("t6_in_hblank_fv", int'(img_fv), 1);
    check("t6_in_hblank_lv", int'(img_lv), 0);
    reset_n = 1'b0;
    @(negedge clk);
    check_idle_outputs("t6_rst");
    reset_n = 1'b1;
    clear_mon();
    trigger = 1'b1;
    run(15);
    check("t6_first_fv", first_fv, 0);
    check("t6_fv", fv_cnt, 12);
    exp_q = '{0, 1, 2, 3, 1, 2, 3, 4};
    check_pix("t6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/image_sensor_emulator.md
# image_sensor_emulator

Synthetic image-sensor source that drives the same parallel pixel bus the camera sensor presents to the CPLD/FPGA path: frame-valid, line-valid, strobe and 12-bit pixel data. It lets FPGA-side capture logic and the camera data path be brought up and regression-tested without a sensor fitted. Frame geometry, blanking and test pattern are set at run time, and frames run either free-running or one per trigger.

## Interface
- CNT_W, 12, width of the geometry and blanking inputs and of the x/y counters.
- clk  in  1  pixel clock; every output changes only on its rising edge.
- reset_n  in  1  synchronous, active-low reset.
- enable  in  1  free-run mode: frames repeat back-to-back while high.
- trigger  in  1  single-cycle request for one frame; honoured only in IDLE.
- width  in  CNT_W  active pixels per line; 0 is treated as 1.
- height  in  CNT_W  active lines per frame; 0 is treated as 1.
- hblank  in  CNT_W  blank cycles between lines (fv=1, lv=0); 0 is treated as 1.
- vblank  in  CNT_W  blank cycles after each frame (fv=0); 0 is treated as 1.
- pattern  in  2  0 = horizontal ramp, 1 = vertical ramp, 2 = checker, 3 = moving diagonal.
- img_fv  out  1  frame valid.
- img_lv  out  1  line valid.
- img_strobe  out  1  exposure strobe, high for the whole of VBLANK.
- img_pix  out  12  pixel data; 0 whenever img_lv=0.
- frame_done  out  1  one-cycle pulse in the EOF cycle.
- busy  out  1  high in every state except IDLE.

## Operation
- States:
  - IDLE
  - SOF (1 cycle, fv=1 lv=0)
  - LINE (width cycles, fv=1 lv=1)
  - HBLANK (hblank cycles, fv=1 lv=0)
  - EOF (1 cycle, fv=1 lv=0)
  - VBLANK (vblank cycles, fv=0 strobe=1)
- Transitions:
  - IDLE→SOF when enable or trigger is sampled high.
  - SOF→LINE.
  - At the end of a LINE: →HBLANK if y < height−1, otherwise →EOF.
  - HBLANK→LINE, with y incremented and x cleared.
  - EOF→VBLANK.
  - At the end of VBLANK: →SOF if enable, otherwise →IDLE.
- width, height, hblank, vblank and pattern are latched, after clamping, on every entry to SOF. Changes during a frame take effect at the next SOF.
- x counts 0..width−1 within a LINE; y counts 0..height−1 across the frame.
- frame_cnt is a 12-bit internal counter, incremented in EOF. It wraps 4095→0 and is cleared by reset.
- Pixel values while lv=1; all arithmetic is mod 4096, using the low 12 bits of x and y:
  - pattern 0: x.
  - pattern 1: y.
  - pattern 2: 12'hFFF if x[3]^y[3], else 0.
  - pattern 3: x + y + frame_cnt.
- trigger is ignored outside IDLE. No request is queued.
- If enable falls mid-frame, the current frame completes, including VBLANK, and the block then enters IDLE.
- enable and trigger both high in IDLE: treated as a single start; free-run continues.

## Timing
- All outputs are registered and reflect the state of the same edge; there is no combinational path from any input to any output.
- Start latency: enable/trigger sampled high at edge k in IDLE → img_fv=1 (SOF) in the cycle after edge k. The first LINE cycle follows one cycle later.
- Per frame: fv is high for 2 + height·width + (height−1)·hblank cycles, followed by vblank cycles with fv=0.
- img_pix is valid in exactly the cycles where img_lv=1. Its value corresponds to that cycle's x/y.
- frame_done coincides with the EOF cycle. frame_cnt holds its new value from the following cycle.
- Reset (reset_n=0 at an edge), including mid-frame: after that edge all outputs are 0, state is IDLE and all counters are 0. The first start is possible on the first edge with reset_n=1.

## Test plan
- Single frame, width=4 height=2 hblank=2 vblank=3 pattern=0, one trigger pulse → expected response:
  - fv high for 12 cycles;
  - lv bursts of 4 cycles with pix 0,1,2,3 in each burst, separated by 2 blank cycles;
  - one frame_done pulse;
  - strobe high for 3 cycles;
  - busy low afterwards.
- Free-run, width=3 height=1 pattern=3 for 3 frames → first-line pix = {0,1,2}, {1,2,3}, {2,3,4}. SOF of each frame follows the last VBLANK cycle directly.
- width=height=hblank=vblank=0 → clamped to 1 each: fv high for 3 cycles, one lv cycle with pix 0, 1 strobe cycle.
- Change width from 4 to 8 mid-frame with pattern=2 → the current frame keeps 4-pixel lines and the next frame uses 8. Checker value toggles at x=8 (pix 12'hFFF for x=8..15 on line 0).
- Drop enable during LINE → the frame completes through VBLANK, then IDLE. A trigger pulsed mid-frame produces no extra frame.
- Assert reset_n=0 during HBLANK → next cycle fv=lv=strobe=busy=0 and pix=0. After release, a trigger starts a fresh frame with frame_cnt=0.
